// File: rtl/mw_countdown_timer.sv
// MM:SS countdown timer with start/pause/stop control and a five-slot multiplexed 7-segment scan.
// Optional build macro DONE_BLINK_EN: after expiry, blink 00:00 for 3 s.
module mw_countdown_timer #(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  output logic       done,
  output logic [7:0] an,
  output logic [7:0] dec_cat
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    mt_reg, mu_reg, st_reg, su_reg;
  logic [3:0]    mt_next, mu_next, st_next, su_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [SW-1:0] scan_reg, scan_next;
  logic [2:0]    slot_reg, slot_next;
  logic          done_reg, done_next;
  logic [7:0]    an_reg, an_next, cat_reg, cat_next;
  logic [7:0]    min_bcd, sec_bcd;
  logic [15:0]   dec_cnt;
  logic [3:0]    disp_digit;
  logic          load_zero;

  // Saturate, then split into tens/units by comparison ladder.
  function automatic logic [7:0] to_bcd(input logic [6:0] v, input logic [6:0] limit);
    logic [6:0] s;
    logic [3:0] tens;
    s = (v > limit) ? limit : v;
    tens = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (s >= 7'(i * 10)) tens = 4'(i);
    end
    return {tens, 4'(s - 7'(tens) * 7'd10)};
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign min_bcd   = to_bcd(min, 7'd99);
  assign sec_bcd   = to_bcd(sec, 7'd59);
  assign load_zero = (min == 7'd0) && (sec == 7'd0);

`ifdef DONE_BLINK_EN
  localparam logic [PW-1:0] Q1 = PW'(CLK_HZ / 4);
  localparam logic [PW-1:0] Q2 = PW'(CLK_HZ / 2);
  localparam logic [PW-1:0] Q3 = PW'((3 * CLK_HZ) / 4);
  logic        blink_reg, blink_next;
  logic [1:0]  blink_sec_reg, blink_sec_next;
  logic [13:0] in_prev_reg;
  logic        blink_on;
  assign blink_on = (presc_reg < Q1) || ((presc_reg >= Q2) && (presc_reg < Q3));
`endif

  // One-second borrow chain; seconds tens wrap to 5 so 01:00 becomes 00:59.
  always_comb begin
    dec_cnt = {mt_reg, mu_reg, st_reg, su_reg};
    if (su_reg != 4'd0) begin
      dec_cnt[3:0] = su_reg - 4'd1;
    end else begin
      dec_cnt[3:0] = 4'd9;
      if (st_reg != 4'd0) begin
        dec_cnt[7:4] = st_reg - 4'd1;
      end else begin
        dec_cnt[7:4] = 4'd5;
        if (mu_reg != 4'd0) begin
          dec_cnt[11:8] = mu_reg - 4'd1;
        end else begin
          dec_cnt[11:8]  = 4'd9;
          dec_cnt[15:12] = mt_reg - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mt_next    = mt_reg;
    mu_next    = mu_reg;
    st_next    = st_reg;
    su_next    = su_reg;
    presc_next = presc_reg;
    done_next  = 1'b0;
    scan_next  = scan_reg + 1'b1;
    slot_next  = slot_reg;
`ifdef DONE_BLINK_EN
    blink_next     = blink_reg;
    blink_sec_next = blink_sec_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        {mt_next, mu_next} = min_bcd;
        {st_next, su_next} = sec_bcd;
        if (!stop && start && !load_zero) begin
          state_next = RUN;
          presc_next = '0;
        end
`ifdef DONE_BLINK_EN
        if (blink_reg) begin
          if (stop || start || ({min, sec} != in_prev_reg)) begin
            blink_next = 1'b0;
          end else if (presc_reg == PRESC_MAX) begin
            presc_next = '0;
            if (blink_sec_reg == 2'd2) blink_next = 1'b0;
            else blink_sec_next = blink_sec_reg + 2'd1;
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
`endif
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (pause) begin
          state_next = PAUSED;
        end else if (presc_reg == PRESC_MAX) begin
          presc_next = '0;
          {mt_next, mu_next, st_next, su_next} = dec_cnt;
          if (dec_cnt == 16'h0000) begin
            done_next  = 1'b1;
            state_next = IDLE;
`ifdef DONE_BLINK_EN
            blink_next     = 1'b1;
            blink_sec_next = 2'd0;
`endif
          end
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      PAUSED: begin
        if (stop) state_next = IDLE;
        else if (pause || start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
    if (scan_reg == SCAN_MAX) begin
      scan_next = '0;
      slot_next = (slot_reg == 3'd4) ? 3'd0 : slot_reg + 3'd1;
    end
  end

  // Slot 4 drives an[5]; an[4], an[6], an[7] are never enabled.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_an
      if (gi < 4) begin : g_digit
        assign an_next[gi] = (slot_reg != 3'(gi));
      end else if (gi == 5) begin : g_power
        assign an_next[gi] = (slot_reg != 3'd4);
      end else begin : g_off
        assign an_next[gi] = 1'b1;
      end
    end
  endgenerate

  always_comb begin
    case (slot_reg)
      3'd1:    disp_digit = st_reg;
      3'd2:    disp_digit = mu_reg;
      3'd3:    disp_digit = mt_reg;
      default: disp_digit = su_reg;
    endcase
`ifdef DONE_BLINK_EN
    if (blink_reg) disp_digit = 4'd0;
`endif
    cat_next = seg7(disp_digit);
    if (slot_reg == 3'd2) cat_next[7] = 1'b0;
`ifdef DONE_BLINK_EN
    if (blink_reg && !blink_on) cat_next = 8'hFF;
`endif
    if (slot_reg == 3'd4) cat_next = 8'hFF;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      mt_reg    <= 4'd0;
      mu_reg    <= 4'd0;
      st_reg    <= 4'd0;
      su_reg    <= 4'd0;
      presc_reg <= '0;
      scan_reg  <= '0;
      slot_reg  <= 3'd0;
      done_reg  <= 1'b0;
      an_reg    <= 8'hFF;
      cat_reg   <= 8'hFF;
`ifdef DONE_BLINK_EN
      blink_reg     <= 1'b0;
      blink_sec_reg <= 2'd0;
      in_prev_reg   <= 14'd0;
`endif
    end else begin
      state_reg <= state_next;
      mt_reg    <= mt_next;
      mu_reg    <= mu_next;
      st_reg    <= st_next;
      su_reg    <= su_next;
      presc_reg <= presc_next;
      scan_reg  <= scan_next;
      slot_reg  <= slot_next;
      done_reg  <= done_next;
      an_reg    <= an_next;
      cat_reg   <= cat_next;
`ifdef DONE_BLINK_EN
      blink_reg     <= blink_next;
      blink_sec_reg <= blink_sec_next;
      in_prev_reg   <= {min, sec};
`endif
    end
  end

  assign done    = done_reg;
  assign an      = an_reg;
  assign dec_cat = cat_reg;

endmodule

// File: tb/tb_mw_countdown_timer.sv
// Directed bench for mw_countdown_timer: IDLE load/saturation table, scan order, and
// run/pause/stop/expiry sequences at CLK_HZ=10, SCAN_DIV=2.
module tb_mw_countdown_timer;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2;

  logic       clock = 1'b0;
  logic       reset, start, pause, stop;
  logic [6:0] min, sec;
  logic       done;
  logic [7:0] an, dec_cat;

  int checks = 0;
  int errors = 0;

  mw_countdown_timer #(.CLK_HZ(10), .SCAN_DIV(2)) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .min(min), .sec(sec), .done(done), .an(an), .dec_cat(dec_cat)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0]  mn;
    logic [6:0]  sc;
    logic [15:0] exp_cnt;
    logic [7:0]  exp_cat;
  } vec_t;

  vec_t       vecs[14];
  logic [7:0] exp_an[5];
  logic [7:0] exp_sc[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
  endtask

  task automatic pulse_pause();
    @(negedge clock); pause = 1'b1;
    @(posedge clock); #1; pause = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clock); stop = 1'b1;
    @(posedge clock); #1; stop = 1'b0;
  endtask

  task automatic set_inputs(input logic [6:0] m, input logic [6:0] s);
    @(negedge clock); min = m; sec = s;
    repeat (2) step();
  endtask

  function automatic logic [15:0] cnt();
    return {dut.mt_reg, dut.mu_reg, dut.st_reg, dut.su_reg};
  endfunction

  initial begin
    int found, bad, n, tick_at, done_seen, done_at, state_at_done;
    logic [7:0]  prev;
    logic [15:0] c0;

    vecs[0]  = '{7'd0,   7'd0,   16'h0000, 8'hC0};
    vecs[1]  = '{7'd0,   7'd3,   16'h0003, 8'hB0};
    vecs[2]  = '{7'd1,   7'd0,   16'h0100, 8'hC0};
    vecs[3]  = '{7'd12,  7'd34,  16'h1234, 8'h99};
    vecs[4]  = '{7'd50,  7'd21,  16'h5021, 8'hF9};
    vecs[5]  = '{7'd33,  7'd42,  16'h3342, 8'hA4};
    vecs[6]  = '{7'd86,  7'd16,  16'h8616, 8'h82};
    vecs[7]  = '{7'd0,   7'd57,  16'h0057, 8'hF8};
    vecs[8]  = '{7'd68,  7'd28,  16'h6828, 8'h80};
    vecs[9]  = '{7'd99,  7'd59,  16'h9959, 8'h90};
    vecs[10] = '{7'd120, 7'd75,  16'h9959, 8'h90};
    vecs[11] = '{7'd45,  7'd60,  16'h4559, 8'h90};
    vecs[12] = '{7'd127, 7'd127, 16'h9959, 8'h90};
    vecs[13] = '{7'd7,   7'd45,  16'h0745, 8'h92};
    // After an[0]: st=5, mu=9 with colon, mt=9, power slot blank, su=9.
    exp_an[0] = 8'hFD; exp_sc[0] = 8'h92;
    exp_an[1] = 8'hFB; exp_sc[1] = 8'h10;
    exp_an[2] = 8'hF7; exp_sc[2] = 8'h90;
    exp_an[3] = 8'hDF; exp_sc[3] = 8'hFF;
    exp_an[4] = 8'hFE; exp_sc[4] = 8'h90;

    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    min = 7'd12; sec = 7'd34;
    repeat (3) step();
    check("rst_an", 32'(an), 32'hFF);
    check("rst_cat", 32'(dec_cat), 32'hFF);
    check("rst_done", 32'(done), 0);
    check("rst_state", 32'(dut.state_reg), S_IDLE);
    check("rst_count", 32'(cnt()), 0);
    check("rst_presc", 32'(dut.presc_reg), 0);
    check("rst_slot", 32'(dut.slot_reg), 0);
    $display("reset: an=%h cat=%h count=%h", an, dec_cat, cnt());
    @(negedge clock); reset = 1'b0;
    step();
    check("first_an", 32'(an), 32'hFE);

    // IDLE load, saturation, BCD conversion and units-digit segment code.
    for (int v = 0; v < 14; v++) begin
      @(negedge clock); min = vecs[v].mn; sec = vecs[v].sc;
      repeat (3) step();
      found = 0;
      for (int k = 0; k < 20; k++) begin
        if (an == 8'hFE) begin found = 1; break; end
        step();
      end
      check("vec_slot0", 32'(found), 1);
      check("vec_count", 32'(cnt()), 32'(vecs[v].exp_cnt));
      check("vec_cat", 32'(dec_cat), 32'(vecs[v].exp_cat));
      $display("vec %0d: min=%0d sec=%0d count=%h cat=%h", v, vecs[v].mn, vecs[v].sc, cnt(), dec_cat);
    end

    // Scan order and blanking with 99:59 shown.
    set_inputs(7'd120, 7'd75);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if ($countones(~an) != 1 || !an[7] || !an[6] || !an[4]) bad++;
    end
    check("an_onehot", 32'(bad), 0);
    found = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (an == 8'hFE) begin found = 1; break; end
    end
    check("scan_fe_found", 32'(found), 1);
    for (int i = 0; i < 5; i++) begin
      prev = an; n = 0;
      for (int j = 0; j < 8; j++) begin
        step(); n++;
        if (an !== prev) break;
      end
      check("scan_an", 32'(an), 32'(exp_an[i]));
      check("scan_cat", 32'(dec_cat), 32'(exp_sc[i]));
      if (i > 0) check("scan_dwell", 32'(n), 2);
      $display("scan %0d: an=%h cat=%h dwell=%0d", i, an, dec_cat, n);
    end

    // 00:03 expires exactly 30 cycles after start, once, back to IDLE.
    set_inputs(7'd0, 7'd3);
    pulse_start();
    check("run_state", 32'(dut.state_reg), S_RUN);
    done_seen = 0; done_at = 0; state_at_done = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done) begin done_seen++; done_at = k; state_at_done = int'(dut.state_reg); end
    end
    check("expire_count", 32'(done_seen), 1);
    check("expire_latency", 32'(done_at), 30);
    check("expire_state", 32'(state_at_done), S_IDLE);
    $display("expire: done pulses=%0d at cycle %0d", done_seen, done_at);

    // 01:00 becomes 00:59 after one tick.
    set_inputs(7'd1, 7'd0);
    pulse_start();
    repeat (9) step();
    check("borrow_before", 32'(cnt()), 32'h0100);
    step();
    check("borrow_after", 32'(cnt()), 32'h0059);
    $display("borrow: count=%h", cnt());
    pulse_stop();
    check("stop_state", 32'(dut.state_reg), S_IDLE);

    // Pause at prescaler 4, hold 50 cycles, resume: tick 6 cycles later.
    set_inputs(7'd0, 7'd5);
    pulse_start();
    repeat (4) step();
    check("pause_presc_pre", 32'(dut.presc_reg), 4);
    pulse_pause();
    check("pause_state", 32'(dut.state_reg), S_PAUSED);
    repeat (50) step();
    check("pause_presc_hold", 32'(dut.presc_reg), 4);
    check("pause_count_hold", 32'(cnt()), 32'h0005);
    pulse_start();
    check("resume_state", 32'(dut.state_reg), S_RUN);
    c0 = cnt(); tick_at = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (tick_at == 0 && cnt() != c0) tick_at = k;
    end
    check("resume_tick_at", 32'(tick_at), 6);
    check("resume_count", 32'(cnt()), 32'h0004);
    $display("resume: tick %0d cycles after resume, count=%h", tick_at, cnt());
    pulse_pause();
    check("toggle_paused", 32'(dut.state_reg), S_PAUSED);
    pulse_pause();
    check("toggle_run", 32'(dut.state_reg), S_RUN);
    pulse_stop();

    // Stop coincident with the expiring tick.
    set_inputs(7'd0, 7'd1);
    pulse_start();
    repeat (9) step();
    @(negedge clock); stop = 1'b1;
    @(posedge clock); #1; stop = 1'b0;
    done_seen = int'(done);
    check("stopexp_state", 32'(dut.state_reg), S_IDLE);
    check("stopexp_count", 32'(cnt()), 32'h0001);
    for (int k = 0; k < 5; k++) begin
      step();
      if (done) done_seen++;
    end
    check("stopexp_done", 32'(done_seen), 0);
    $display("stop at expiry: state=%0d done pulses=%0d", dut.state_reg, done_seen);

    // Start at 00:00 is ignored.
    set_inputs(7'd0, 7'd0);
    pulse_start();
    done_seen = int'(done);
    check("zero_state", 32'(dut.state_reg), S_IDLE);
    for (int k = 0; k < 5; k++) begin
      step();
      if (done) done_seen++;
    end
    check("zero_done", 32'(done_seen), 0);
    $display("start at zero: state=%0d done pulses=%0d", dut.state_reg, done_seen);

    // Asynchronous reset mid-count aborts without done.
    set_inputs(7'd0, 7'd2);
    pulse_start();
    repeat (15) step();
    check("midrst_running", 32'(cnt()), 32'h0001);
    #2 reset = 1'b1;
    #1;
    check("midrst_state", 32'(dut.state_reg), S_IDLE);
    check("midrst_count", 32'(cnt()), 0);
    check("midrst_an", 32'(an), 32'hFF);
    check("midrst_cat", 32'(dec_cat), 32'hFF);
    @(negedge clock); reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done) done_seen++;
    end
    check("midrst_done", 32'(done_seen), 0);
    check("midrst_idle", 32'(dut.state_reg), S_IDLE);
    $display("reset mid-count: done pulses=%0d", done_seen);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mw_countdown_timer.md
MW_COUNTDOWN_TIMER -- requirements
Module: mw_countdown_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, clock cycles per one-second tick.
REQ-002 The block SHALL have parameter SCAN_DIV, default 100000, clock cycles per display digit slot.
REQ-003 The block SHALL have port clock  input  1  system clock, on which all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port start  input  1  single-cycle start/resume request.
REQ-006 The block SHALL have port pause  input  1  single-cycle pause toggle request.
REQ-007 The block SHALL have port stop  input  1  level-sensitive abort, acting in every cycle it is high.
REQ-008 The block SHALL have port min  input  7  programmed minutes, binary.
REQ-009 The block SHALL have port sec  input  7  programmed seconds, binary.
REQ-010 The block SHALL have port done  output  1  single-cycle pulse when the count expires.
REQ-011 The block SHALL have port an  output  8  active-low digit anodes.
REQ-012 The block SHALL have port dec_cat  output  8  active-low cathodes {dp,g,f,e,d,c,b,a}.

Function
REQ-013 The block SHALL hold the count as four BCD digits: mt, mu, st, su.
REQ-014 The state machine SHALL have three states: IDLE, RUN, PAUSED.
REQ-015 In IDLE, the count SHALL load from the inputs every cycle, with min saturated to 99, sec saturated to 59, and binary converted to BCD.
REQ-016 In IDLE, start SHALL enter RUN if the count is non-zero and clear the prescaler; start at 00:00 SHALL be ignored and SHALL NOT pulse done.
REQ-017 In RUN, the prescaler SHALL count 0..CLK_HZ-1 and generate a tick on wrap.
REQ-018 Decrement on tick: su, then st, then mu, then mt, with borrow; seconds SHALL wrap 00 to 59 when minutes are non-zero.
REQ-019 A tick that yields 00:00 SHALL assert done for exactly one cycle in the following cycle and return the block to IDLE.
REQ-020 In RUN, pause SHALL enter PAUSED with the prescaler and count frozen, suppressing any tick in the same cycle.
REQ-021 In PAUSED, pause or start SHALL enter RUN, with the prescaler resuming from its frozen value.
REQ-022 In any state, stop SHALL enter IDLE and SHALL NOT pulse done; priority SHALL be stop > pause/start > tick.
REQ-023 The scanner SHALL advance one slot every SCAN_DIV cycles in the order an[0], an[1], an[2], an[3], an[5], then repeat; exactly one anode SHALL be low at a time.
REQ-024 Anode-to-digit mapping SHALL be: an[0]=su, an[1]=st, an[2]=mu, an[3]=mt.
REQ-025 The dp cathode SHALL be lit only in the an[2] slot, acting as the colon.
REQ-026 In the an[5] slot, dec_cat SHALL be 8'hFF, leaving the slot to the power digit.
REQ-027 an[4], an[6] and an[7] SHALL remain high at all times.
REQ-028 Segment codes (dp off) SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
REQ-029 Outputs SHALL be registered, with one cycle of latency from a slot change to the an/dec_cat update.

Reset
REQ-030 Reset SHALL force: state IDLE, count 00:00, prescaler 0, scan counter 0, slot an[0], done 0.
REQ-031 Reset SHALL force an to 8'hFF and dec_cat to 8'hFF until the first registered update after reset release.
REQ-032 Reset asserted mid-count SHALL abort the count and SHALL NOT pulse done.

Configuration
REQ-033 With DONE_BLINK_EN defined, after done the time digits SHALL blink 00:00 (0.25 s on, 0.25 s off, counted by the prescaler) for 3 s, or until start, stop or a changed input; off-phase cathodes SHALL be 8'hFF.
REQ-034 Without DONE_BLINK_EN, the display SHALL show the IDLE count steadily, with no blink logic present.

Verification
REQ-035 Bench SHALL run CLK_HZ=10, SCAN_DIV=2, min=0, sec=3, then pulse start: done pulses exactly 30 cycles later, once, and the state returns to IDLE.
REQ-036 Bench SHALL apply min=1, sec=0, then start: after 1 tick the count is 00:59 (mu=0, st=5, su=9).
REQ-037 Bench SHALL pulse pause in RUN at prescaler=4, hold 50 cycles, then pulse start: the next tick occurs 6 cycles after resume.
REQ-038 Bench SHALL assert stop together with the expiring tick: the state is IDLE and done stays 0.
REQ-039 Bench SHALL apply min=120, sec=75: the display shows 99:59, the an sequence is FE, FD, FB, F7, DF, and dec_cat=FF in the an[5] slot.
REQ-040 Bench SHALL pulse start with min=0, sec=0: the state remains IDLE and done stays 0.
